ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Consumer end of the 9-bit decoded control word produced by the ID-stage decoder.
- Carries control bits through the ID/EX, EX/MEM and MEM/WB pipeline registers and delivers each field in the stage that uses it.
- Owns load-use hazard detection (stall plus bubble insertion), branch-taken flush, and the EX-stage forwarding selects of the 5-stage pipeline.

Parameters:
- CTRL_W, 9, width of decoded control word.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_ctrl  in  CTRL_W  decoded control word. Bit layout: [8] memtoreg, [7] regwrite, [6] memwrite, [5] memread, [4] branch, [3] alusrc, [2:1] aluop, [0] regdst
- id_rs  in  REG_AW  rs of the instruction in ID
- id_rt  in  REG_AW  rt of the instruction in ID
- id_rd  in  REG_AW  rd of the instruction in ID
- mem_zero  in  1  registered ALU zero flag of the instruction in MEM
- ex_alusrc  out  1  ALU B-operand select, immediate when 1
- ex_aluop  out  2  0 add, 1 sub, 2 funct, 3 lui
- ex_wreg  out  REG_AW  destination: rd if regdst else rt
- fwd_a  out  2  ALU A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- fwd_b  out  2  ALU B select, same encoding as fwd_a
- mem_memread  out  1  data-memory read enable
- mem_memwrite  out  1  data-memory write enable
- mem_wreg  out  REG_AW  destination register in MEM
- pc_src  out  1  branch taken: mem_branch & mem_zero
- wb_memtoreg  out  1  writeback select, memory data when 1
- wb_regwrite  out  1  register-file write enable
- wb_wreg  out  REG_AW  register-file write address
- stall  out  1  hold PC and IF/ID this cycle
- flush_ifid  out  1  zero IF/ID this cycle

Behaviour:
- Reset: every stage register (control fields and register addresses) clears to 0 on the reset clock edge. All outputs read 0 in the following cycle, including stall, flush_ifid, pc_src, fwd_a and fwd_b. Reset overrides stall and flush; an in-flight instruction is discarded.
- ID/EX register holds ctrl[8:0], rs, rt and the selected wreg. EX/MEM holds [8:4] and wreg. MEM/WB holds [8:7] and wreg.
- Every stage advances every cycle. There is no global enable; latency from ID to WB is 3 edges.
- Load-use hazard (combinational): stall = ex_memread & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt) & ~pc_src.
  - The rt comparison is applied regardless of instruction type (conservative).
  - While stall=1, the ID/EX control word loads 0 (bubble); its register addresses load don't-care.
  - EX/MEM and MEM/WB advance normally.
  - A stall lasts exactly one cycle per load.
- Branch (combinational): pc_src = mem_branch & mem_zero, and flush_ifid = pc_src.
  - At that edge, the ID/EX and EX/MEM control words load 0.
  - MEM/WB loads normally; the branch has no WB effect.
- Simultaneous stall and branch: the flush wins and stall is forced to 0.
- Forwarding (combinational, fwd_a for ex_rs, fwd_b for ex_rt):
  - Select 10 if mem_regwrite & mem_wreg != 0 & mem_wreg == src.
  - Else select 01 if wb_regwrite & wb_wreg != 0 & wb_wreg == src.
  - Else select 00. EX/MEM has priority over MEM/WB.
- Register 0 is never a hazard or forwarding source.

Decomposition:
- Package mips_ctrl_pkg:
  - control bit index constants (CTRL_MEMTOREG=8 … CTRL_REGDST=0)
  - ALUOP_ADD/SUB/FUNCT/LUI
  - FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01
- Sub-module: ctrl_fwd_unit, the combinational forwarding compare, instantiated once and producing fwd_a and fwd_b.

Test Plan:
- Reset: drive id_ctrl=0x1FF and id_rs/id_rt/id_rd=31, assert reset 2 cycles -> all outputs 0. Re-assert reset mid-stream with 3 instructions in flight -> all outputs 0 the next cycle.
- R-type: id_ctrl=0x085, rd=3, rt=7 -> +1 cycle: ex_aluop=2, ex_alusrc=0, ex_wreg=3. +3 cycles: wb_regwrite=1, wb_memtoreg=0, wb_wreg=3.
- Load-use: lw id_ctrl=0x1A8 with rt=5, followed by add with rs=5, rt=6.
  - When lw is in EX: stall=1 for 1 cycle, and the next ex_* fields are 0.
  - Add enters EX when lw is in WB: fwd_a=01, fwd_b=00.
  - Repeat with rt=0 -> stall=0.
- Forwarding: add rd=4, then add rs=4, rt=4 -> fwd_a=fwd_b=10. With one unrelated instruction between them -> 01. With rd=0 -> 00.
- Branch: beq id_ctrl=0x012.
  - In MEM with mem_zero=1: pc_src=flush_ifid=1, and EX/MEM-stage outputs are 0 next cycle.
  - With mem_zero=0: no flush, younger instructions proceed.
- Priority: lw-use stall pending in the same cycle beq resolves taken -> stall=0, flush_ifid=1, both younger stages zeroed.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared control-word layout, ALU op codes and forwarding-select encodings
// for the 5-stage pipeline control path.
package mips_ctrl_pkg;

  localparam int unsigned CTRL_W = 9;
  localparam int unsigned REG_AW = 5;

  localparam int unsigned CTRL_MEMTOREG = 8;
  localparam int unsigned CTRL_REGWRITE = 7;
  localparam int unsigned CTRL_MEMWRITE = 6;
  localparam int unsigned CTRL_MEMREAD  = 5;
  localparam int unsigned CTRL_BRANCH   = 4;
  localparam int unsigned CTRL_ALUSRC   = 3;
  localparam int unsigned CTRL_ALUOP_HI = 2;
  localparam int unsigned CTRL_ALUOP_LO = 1;
  localparam int unsigned CTRL_REGDST   = 0;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_LUI   = 2'd3;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Full decoded word, field order matches the decoder's bit layout
  typedef struct packed {
    logic       memtoreg;
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       branch;
    logic       alusrc;
    logic [1:0] aluop;
    logic       regdst;
  } ctrl_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
    logic memwrite;
    logic memread;
    logic branch;
  } mem_ctrl_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } wb_ctrl_t;

  // EX/MEM result beats MEM/WB; register 0 never forwards
  function automatic logic [1:0] fwd_sel(
    input logic              mem_regwrite,
    input logic [REG_AW-1:0] mem_wreg,
    input logic              wb_regwrite,
    input logic [REG_AW-1:0] wb_wreg,
    input logic [REG_AW-1:0] src
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_regwrite && (mem_wreg != '0) && (mem_wreg == src)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_wreg != '0) && (wb_wreg == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ctrl_fwd_unit.sv
// EX-stage forwarding compare: picks the ALU A/B operand source from the
// destination registers of the two older in-flight instructions.
module ctrl_fwd_unit
  import mips_ctrl_pkg::*;
(
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_wreg,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_wreg,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  always_comb begin
    fwd_a = fwd_sel(mem_regwrite, mem_wreg, wb_regwrite, wb_wreg, ex_rs);
    fwd_b = fwd_sel(mem_regwrite, mem_wreg, wb_regwrite, wb_wreg, ex_rt);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipeline control path: carries the decoded control word from ID to WB and
// owns load-use stall, branch flush and forwarding selects.
module ctrl_pipe
  import mips_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              mem_zero,
  output logic              ex_alusrc,
  output logic [1:0]        ex_aluop,
  output logic [REG_AW-1:0] ex_wreg,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic [REG_AW-1:0] mem_wreg,
  output logic              pc_src,
  output logic              wb_memtoreg,
  output logic              wb_regwrite,
  output logic [REG_AW-1:0] wb_wreg,
  output logic              stall,
  output logic              flush_ifid
);

  ctrl_t             r_ex_ctrl;
  logic [REG_AW-1:0] r_ex_rs;
  logic [REG_AW-1:0] r_ex_rt;
  logic [REG_AW-1:0] r_ex_wreg;
  mem_ctrl_t         r_mem_ctrl;
  logic [REG_AW-1:0] r_mem_wreg;
  wb_ctrl_t          r_wb_ctrl;
  logic [REG_AW-1:0] r_wb_wreg;

  ctrl_t             w_id_ctrl;
  logic [REG_AW-1:0] w_id_wreg;
  logic              w_pc_src;
  logic              w_stall;
  logic              w_kill_ex;
  logic              w_unused_regdst;

  assign w_id_ctrl = ctrl_t'(id_ctrl);
  assign w_id_wreg = w_id_ctrl.regdst ? id_rd : id_rt;

  // Taken branch resolves in MEM; it outranks a pending load-use stall
  assign w_pc_src  = r_mem_ctrl.branch & mem_zero;
  assign w_stall   = r_ex_ctrl.memread & (r_ex_rt != '0)
                   & ((r_ex_rt == id_rs) | (r_ex_rt == id_rt)) & ~w_pc_src;
  assign w_kill_ex = w_stall | w_pc_src;

  // regdst is consumed in ID when the destination is selected
  assign w_unused_regdst = r_ex_ctrl.regdst;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_ctrl  <= '0;
      r_ex_rs    <= '0;
      r_ex_rt    <= '0;
      r_ex_wreg  <= '0;
      r_mem_ctrl <= '0;
      r_mem_wreg <= '0;
      r_wb_ctrl  <= '0;
      r_wb_wreg  <= '0;
    end else begin
      // Bubble or squash: the whole ID/EX entry is cleared
      if (w_kill_ex) begin
        r_ex_ctrl <= '0;
        r_ex_rs   <= '0;
        r_ex_rt   <= '0;
        r_ex_wreg <= '0;
      end else begin
        r_ex_ctrl <= w_id_ctrl;
        r_ex_rs   <= id_rs;
        r_ex_rt   <= id_rt;
        r_ex_wreg <= w_id_wreg;
      end

      if (w_pc_src) begin
        r_mem_ctrl <= '0;
      end else begin
        r_mem_ctrl.memtoreg <= r_ex_ctrl.memtoreg;
        r_mem_ctrl.regwrite <= r_ex_ctrl.regwrite;
        r_mem_ctrl.memwrite <= r_ex_ctrl.memwrite;
        r_mem_ctrl.memread  <= r_ex_ctrl.memread;
        r_mem_ctrl.branch   <= r_ex_ctrl.branch;
      end
      r_mem_wreg <= r_ex_wreg;

      r_wb_ctrl.memtoreg <= r_mem_ctrl.memtoreg;
      r_wb_ctrl.regwrite <= r_mem_ctrl.regwrite;
      r_wb_wreg          <= r_mem_wreg;
    end
  end

  ctrl_fwd_unit u_fwd (
    .mem_regwrite (r_mem_ctrl.regwrite),
    .mem_wreg     (r_mem_wreg),
    .wb_regwrite  (r_wb_ctrl.regwrite),
    .wb_wreg      (r_wb_wreg),
    .ex_rs        (r_ex_rs),
    .ex_rt        (r_ex_rt),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  assign ex_alusrc    = r_ex_ctrl.alusrc;
  assign ex_aluop     = r_ex_ctrl.aluop;
  assign ex_wreg      = r_ex_wreg;
  assign mem_memread  = r_mem_ctrl.memread;
  assign mem_memwrite = r_mem_ctrl.memwrite;
  assign mem_wreg     = r_mem_wreg;
  assign pc_src       = w_pc_src;
  assign wb_memtoreg  = r_wb_ctrl.memtoreg;
  assign wb_regwrite  = r_wb_ctrl.regwrite;
  assign wb_wreg      = r_wb_wreg;
  assign stall        = w_stall;
  assign flush_ifid   = w_pc_src;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: reset, R-type flow, load-use, forwarding,
// branch flush and stall/flush priority with hand-computed expectations.
module tb_ctrl_pipe;

  localparam logic [8:0] C_NOP = 9'h000;
  localparam logic [8:0] C_ADD = 9'h085;
  localparam logic [8:0] C_LW  = 9'h1A8;
  localparam logic [8:0] C_BEQ = 9'h012;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] id_ctrl;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       mem_zero;
  logic       ex_alusrc;
  logic [1:0] ex_aluop;
  logic [4:0] ex_wreg;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_memread, mem_memwrite;
  logic [4:0] mem_wreg;
  logic       pc_src;
  logic       wb_memtoreg, wb_regwrite;
  logic [4:0] wb_wreg;
  logic       stall, flush_ifid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk          (clk),
    .reset        (reset),
    .id_ctrl      (id_ctrl),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .mem_zero     (mem_zero),
    .ex_alusrc    (ex_alusrc),
    .ex_aluop     (ex_aluop),
    .ex_wreg      (ex_wreg),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .mem_wreg     (mem_wreg),
    .pc_src       (pc_src),
    .wb_memtoreg  (wb_memtoreg),
    .wb_regwrite  (wb_regwrite),
    .wb_wreg      (wb_wreg),
    .stall        (stall),
    .flush_ifid   (flush_ifid)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [8:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd);
    id_ctrl = c;
    id_rs   = rs;
    id_rt   = rt;
    id_rd   = rd;
  endtask

  task automatic nops(input int n);
    drive(C_NOP, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ex_alusrc"},    8'(ex_alusrc),    8'd0);
    chk({tag, ".ex_aluop"},     8'(ex_aluop),     8'd0);
    chk({tag, ".ex_wreg"},      8'(ex_wreg),      8'd0);
    chk({tag, ".fwd_a"},        8'(fwd_a),        8'd0);
    chk({tag, ".fwd_b"},        8'(fwd_b),        8'd0);
    chk({tag, ".mem_memread"},  8'(mem_memread),  8'd0);
    chk({tag, ".mem_memwrite"}, 8'(mem_memwrite), 8'd0);
    chk({tag, ".mem_wreg"},     8'(mem_wreg),     8'd0);
    chk({tag, ".pc_src"},       8'(pc_src),       8'd0);
    chk({tag, ".wb_memtoreg"},  8'(wb_memtoreg),  8'd0);
    chk({tag, ".wb_regwrite"},  8'(wb_regwrite),  8'd0);
    chk({tag, ".wb_wreg"},      8'(wb_wreg),      8'd0);
    chk({tag, ".stall"},        8'(stall),        8'd0);
    chk({tag, ".flush_ifid"},   8'(flush_ifid),   8'd0);
  endtask

  initial begin
    // Reset with every input at its most active value
    reset    = 1'b1;
    mem_zero = 1'b1;
    drive(9'h1FF, 5'd31, 5'd31, 5'd31);
    tick();
    tick();
    chk_all_zero("reset");
    reset    = 1'b0;
    mem_zero = 1'b0;
    nops(3);

    // R-type: rd=3 via regdst
    drive(C_ADD, 5'd1, 5'd7, 5'd3);
    tick();
    drive(C_NOP, 5'd0, 5'd0, 5'd0);
    settle();
    chk("rtype.ex_aluop",  8'(ex_aluop),  8'd2);
    chk("rtype.ex_alusrc", 8'(ex_alusrc), 8'd0);
    chk("rtype.ex_wreg",   8'(ex_wreg),   8'd3);
    tick();
    tick();
    chk("rtype.wb_regwrite", 8'(wb_regwrite), 8'd1);
    chk("rtype.wb_memtoreg", 8'(wb_memtoreg), 8'd0);
    chk("rtype.wb_wreg",     8'(wb_wreg),     8'd3);
    nops(3);

    // Load-use: lw rt=5 then add rs=5
    drive(C_LW, 5'd1, 5'd5, 5'd9);
    tick();
    drive(C_ADD, 5'd5, 5'd6, 5'd8);
    settle();
    chk("lu.stall",      8'(stall),      8'd1);
    chk("lu.flush_ifid", 8'(flush_ifid), 8'd0);
    tick();
    chk("lu.bubble_aluop",  8'(ex_aluop),    8'd0);
    chk("lu.bubble_alusrc", 8'(ex_alusrc),   8'd0);
    chk("lu.stall_once",    8'(stall),       8'd0);
    chk("lu.mem_memread",   8'(mem_memread), 8'd1);
    chk("lu.mem_wreg",      8'(mem_wreg),    8'd5);
    tick();
    drive(C_NOP, 5'd0, 5'd0, 5'd0);
    settle();
    chk("lu.fwd_a",       8'(fwd_a),       8'd1);
    chk("lu.fwd_b",       8'(fwd_b),       8'd0);
    chk("lu.ex_wreg",     8'(ex_wreg),     8'd8);
    chk("lu.wb_memtoreg", 8'(wb_memtoreg), 8'd1);
    chk("lu.wb_wreg",     8'(wb_wreg),     8'd5);
    nops(3);

    // Load with rt=0 never stalls
    drive(C_LW, 5'd1, 5'd0, 5'd0);
    tick();
    drive(C_ADD, 5'd0, 5'd6, 5'd8);
    settle();
    chk("lu0.stall", 8'(stall), 8'd0);
    tick();
    chk("lu0.ex_aluop", 8'(ex_aluop), 8'd2);
    nops(3);

    // Forwarding from EX/MEM
    drive(C_ADD, 5'd1, 5'd2, 5'd4);
    tick();
    drive(C_ADD, 5'd4, 5'd4, 5'd9);
    tick();
    chk("fwdm.fwd_a", 8'(fwd_a), 8'd2);
    chk("fwdm.fwd_b", 8'(fwd_b), 8'd2);
    nops(3);

    // Forwarding from MEM/WB with an unrelated instruction between
    drive(C_ADD, 5'd1, 5'd2, 5'd4);
    tick();
    drive(C_ADD, 5'd10, 5'd11, 5'd12);
    tick();
    drive(C_ADD, 5'd4, 5'd4, 5'd9);
    tick();
    chk("fwdw.fwd_a", 8'(fwd_a), 8'd1);
    chk("fwdw.fwd_b", 8'(fwd_b), 8'd1);
    nops(3);

    // Both older stages write r4: EX/MEM wins
    drive(C_ADD, 5'd1, 5'd2, 5'd4);
    tick();
    drive(C_ADD, 5'd3, 5'd2, 5'd4);
    tick();
    drive(C_ADD, 5'd4, 5'd13, 5'd9);
    tick();
    chk("fwdp.fwd_a", 8'(fwd_a), 8'd2);
    chk("fwdp.fwd_b", 8'(fwd_b), 8'd0);
    nops(3);

    // Register 0 destination never forwards
    drive(C_ADD, 5'd1, 5'd2, 5'd0);
    tick();
    drive(C_ADD, 5'd0, 5'd0, 5'd9);
    tick();
    chk("fwd0.fwd_a", 8'(fwd_a), 8'd0);
    chk("fwd0.fwd_b", 8'(fwd_b), 8'd0);
    nops(3);

    // Taken branch squashes the lw in EX and the add in ID
    drive(C_BEQ, 5'd1, 5'd2, 5'd0);
    tick();
    drive(C_LW, 5'd3, 5'd7, 5'd0);
    tick();
    drive(C_ADD, 5'd8, 5'd9, 5'd10);
    mem_zero = 1'b1;
    settle();
    chk("brt.pc_src",     8'(pc_src),     8'd1);
    chk("brt.flush_ifid", 8'(flush_ifid), 8'd1);
    tick();
    mem_zero = 1'b0;
    drive(C_NOP, 5'd0, 5'd0, 5'd0);
    settle();
    chk("brt.mem_memread",  8'(mem_memread),  8'd0);
    chk("brt.ex_aluop",     8'(ex_aluop),     8'd0);
    chk("brt.wb_regwrite",  8'(wb_regwrite),  8'd0);
    chk("brt.pc_src_after", 8'(pc_src),       8'd0);
    nops(3);

    // Branch not taken: younger instructions proceed
    drive(C_BEQ, 5'd1, 5'd2, 5'd0);
    tick();
    drive(C_LW, 5'd3, 5'd7, 5'd0);
    tick();
    drive(C_ADD, 5'd8, 5'd9, 5'd10);
    settle();
    chk("brn.pc_src",     8'(pc_src),     8'd0);
    chk("brn.flush_ifid", 8'(flush_ifid), 8'd0);
    tick();
    drive(C_NOP, 5'd0, 5'd0, 5'd0);
    settle();
    chk("brn.mem_memread", 8'(mem_memread), 8'd1);
    chk("brn.mem_wreg",    8'(mem_wreg),    8'd7);
    chk("brn.ex_aluop",    8'(ex_aluop),    8'd2);
    nops(3);

    // Load-use pending while branch resolves taken
    drive(C_BEQ, 5'd1, 5'd2, 5'd0);
    tick();
    drive(C_LW, 5'd1, 5'd5, 5'd0);
    tick();
    drive(C_ADD, 5'd5, 5'd6, 5'd8);
    mem_zero = 1'b1;
    settle();
    chk("prio.stall",      8'(stall),      8'd0);
    chk("prio.flush_ifid", 8'(flush_ifid), 8'd1);
    tick();
    mem_zero = 1'b0;
    drive(C_NOP, 5'd0, 5'd0, 5'd0);
    settle();
    chk("prio.ex_aluop",    8'(ex_aluop),    8'd0);
    chk("prio.mem_memread", 8'(mem_memread), 8'd0);
    nops(3);

    // Reset mid-stream with three instructions in flight
    drive(C_ADD, 5'd1, 5'd2, 5'd3);
    tick();
    drive(C_LW, 5'd1, 5'd5, 5'd0);
    tick();
    drive(C_ADD, 5'd2, 5'd7, 5'd6);
    tick();
    chk("mid.wb_regwrite_pre", 8'(wb_regwrite), 8'd1);
    reset    = 1'b1;
    mem_zero = 1'b1;
    drive(9'h1FF, 5'd31, 5'd31, 5'd31);
    tick();
    reset = 1'b0;
    settle();
    chk_all_zero("midreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
